// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch stage.
package instruction_fetch_unit_pkg;

  localparam int          PC_WIDTH         = 32;
  localparam logic [31:0] PC_INCR          = 32'd4;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, pc_plus4: 32'h0, valid: 1'b0};

  // Redirect targets are forced onto a word boundary before reaching the PC.
  function automatic logic [PC_WIDTH-1:0] word_align(input logic [PC_WIDTH-1:0] addr);
    return {addr[PC_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_ifid_register.sv
// IF/ID pipeline register: flush wins over load; neither means hold.
module ifid_register
  import instruction_fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_plus4_in,
  output logic [31:0] instr_out,
  output logic [31:0] pc_plus4_out,
  output logic        valid_out
);

  ifid_t ifid_q, ifid_d;

  always_comb begin
    ifid_d = ifid_q;
    if (flush) begin
      ifid_d = IFID_BUBBLE;
    end else if (load) begin
      ifid_d = '{instr: instr_in, pc_plus4: pc_plus4_in, valid: 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifid_q <= IFID_BUBBLE;
    end else begin
      ifid_q <= ifid_d;
    end
  end

  assign instr_out    = ifid_q.instr;
  assign pc_plus4_out = ifid_q.pc_plus4;
  assign valid_out    = ifid_q.valid;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives the instruction memory address and fills IF/ID.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          IMEM_WORDS = 128
) (
  input  logic        Clk,
  input  logic        Rst,
  output logic [31:0] InstrAddress,
  input  logic [31:0] Instruction,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        JumpTaken,
  input  logic [31:0] JumpTarget,
  output logic [31:0] IFID_Instruction,
  output logic [31:0] IFID_PCPlus4,
  output logic        IFID_Valid,
  output logic        AddrOutOfRange,
  output logic [31:0] FetchCount
);

  localparam logic [31:0] IMEM_WORDS_W = 32'(IMEM_WORDS);

  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] pc_plus4;
  logic        ifid_load;

  assign redirect        = BranchTaken | JumpTaken;
  // The branch belongs to the older instruction, so it beats a same-cycle jump.
  assign redirect_target = word_align(BranchTaken ? BranchTarget : JumpTarget);
  assign pc_plus4        = pc_q + PC_INCR;
  assign ifid_load       = !redirect && !Stall;

  always_comb begin
    pc_d          = pc_q;
    fetch_count_d = fetch_count_q;
    if (redirect) begin
      pc_d = redirect_target;
    end else if (!Stall) begin
      pc_d          = pc_plus4;
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      pc_q          <= RESET_PC;
      fetch_count_q <= 32'h0;
    end else begin
      pc_q          <= pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  ifid_register u_ifid (
    .clk          (Clk),
    .rst          (Rst),
    .load         (ifid_load),
    .flush        (redirect),
    .instr_in     (Instruction),
    .pc_plus4_in  (pc_plus4),
    .instr_out    (IFID_Instruction),
    .pc_plus4_out (IFID_PCPlus4),
    .valid_out    (IFID_Valid)
  );

  assign InstrAddress   = pc_q;
  assign FetchCount     = fetch_count_q;
  assign AddrOutOfRange = {2'b00, pc_q[31:2]} >= IMEM_WORDS_W;

endmodule
